// File: rtl/uart_result_reporter_if.sv
// uart_result_reporter_if: request/result inputs and serial output of the result reporter.
interface uart_result_reporter_if #(
    parameter int RESULT_SIZE = 4,
    parameter int ERROR_COUNT = 2
);
    localparam int EW = ERROR_COUNT > 1 ? $clog2(ERROR_COUNT) : 1;
    logic ready_in;
    logic [4*RESULT_SIZE-1:0] data_in;
    logic [EW-1:0] error_in;
    logic RsTx;
    modport master(output ready_in, data_in, error_in, input RsTx);
    modport slave(input ready_in, data_in, error_in, output RsTx);
endinterface

// File: rtl/uart_result_reporter.sv
// uart_result_reporter: formats a hex result or error code as an ASCII line and sends it as 8N1 UART.
module uart_result_reporter #(
    parameter int ERROR_COUNT = 2,
    parameter int RESULT_SIZE = 4,
    parameter int CLOCK_RATE = 100_000_000,
    parameter int BAUD_RATE = 9600
) (
    input logic clk,
    input logic reset,
    uart_result_reporter_if.slave bus
);
    localparam int EW = ERROR_COUNT > 1 ? $clog2(ERROR_COUNT) : 1;
    localparam int ED = (EW + 3) / 4;
    localparam int RL = 8 + RESULT_SIZE + 2;
    localparam int EL = 7 + ED + 3;
    localparam int DEPTH = RL > EL ? RL : EL;
    localparam int BP = CLOCK_RATE / BAUD_RATE;
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = BP > 1 ? $clog2(BP) : 1;
    localparam logic [63:0] RES_STR = "Result: ";
    localparam logic [55:0] ERR_STR = "Error: ";

    typedef enum logic {F_IDLE, F_SEND} fstate_t;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} sstate_t;

    fstate_t fstate;
    logic [CW-1:0] cnt;
    logic is_err;
    logic [4*RESULT_SIZE-1:0] data_q;
    logic [4*ED-1:0] err_q;
    logic [7:0] ch;
    int c;
    logic wr, rd, full, empty, last;
    logic [7:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [CW-1:0] level;
    sstate_t sstate;
    logic [7:0] shreg;
    logic [2:0] bitn;
    logic [TW-1:0] tcnt;
    logic tx;

    function automatic logic [7:0] hex(input logic [3:0] n);
        return n < 4'd10 ? {4'h3, n} : 8'h37 + {4'h0, n};
    endfunction

    // Character at position cnt of the selected line, most significant nibble first.
    always_comb begin
        c = int'(cnt);
        ch = 8'h0A;
        if (!is_err)
            ch = c < 8 ? RES_STR[63-8*c -: 8] :
                 c < 8 + RESULT_SIZE ? hex(data_q[4*(RESULT_SIZE+7-c) +: 4]) :
                 c == 8 + RESULT_SIZE ? 8'h0D : 8'h0A;
        else
            ch = c < 7 ? ERR_STR[55-8*c -: 8] :
                 c < 7 + ED ? hex(err_q[4*(ED+6-c) +: 4]) :
                 c == 7 + ED ? 8'h21 :
                 c == 8 + ED ? 8'h0D : 8'h0A;
    end

    assign last = cnt == CW'(is_err ? EL - 1 : RL - 1);
    assign full = level == CW'(DEPTH);
    assign empty = level == '0;
    assign wr = fstate == F_SEND && !full;
    assign rd = sstate == S_IDLE && !empty;
    assign bus.RsTx = tx;

    always_ff @(posedge clk) begin
        if (reset) begin
            fstate <= F_IDLE;
            cnt <= '0;
            is_err <= 1'b0;
            data_q <= '0;
            err_q <= '0;
        end else if (fstate == F_IDLE) begin
            if (bus.ready_in) begin
                fstate <= F_SEND;
                cnt <= '0;
                is_err <= bus.error_in != '0;
                data_q <= bus.data_in;
                err_q <= (4*ED)'(bus.error_in);
            end
        end else if (!full) begin
            if (last) fstate <= F_IDLE;
            else cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
            level <= '0;
        end else begin
            if (wr) begin
                mem[wp] <= ch;
                wp <= wp == AW'(DEPTH - 1) ? '0 : wp + AW'(1);
            end
            if (rd) rp <= rp == AW'(DEPTH - 1) ? '0 : rp + AW'(1);
            level <= level + CW'(wr) - CW'(rd);
        end
    end

    // Data bits shift out of shreg; tx is registered so each bit holds exactly BP cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            sstate <= S_IDLE;
            tx <= 1'b1;
            tcnt <= '0;
            bitn <= '0;
            shreg <= '0;
        end else begin
            case (sstate)
                S_IDLE: if (!empty) begin
                    shreg <= mem[rp];
                    tx <= 1'b0;
                    tcnt <= '0;
                    sstate <= S_START;
                end
                S_START: if (tcnt == TW'(BP - 1)) begin
                    tcnt <= '0;
                    tx <= shreg[0];
                    bitn <= '0;
                    sstate <= S_DATA;
                end else tcnt <= tcnt + TW'(1);
                S_DATA: if (tcnt == TW'(BP - 1)) begin
                    tcnt <= '0;
                    shreg <= shreg >> 1;
                    tx <= bitn == 3'd7 ? 1'b1 : shreg[1];
                    bitn <= bitn + 3'd1;
                    sstate <= bitn == 3'd7 ? S_STOP : S_DATA;
                end else tcnt <= tcnt + TW'(1);
                S_STOP: if (tcnt == TW'(BP - 1)) begin
                    tcnt <= '0;
                    sstate <= S_IDLE;
                end else tcnt <= tcnt + TW'(1);
            endcase
        end
    end
endmodule

// File: tb/tb_uart_result_reporter.sv
// tb_uart_result_reporter: scoreboard bench with a bit-accurate UART monitor at BP = 16.
module tb_uart_result_reporter;
    localparam int BP = 16;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_result_reporter_if #(.RESULT_SIZE(4), .ERROR_COUNT(2)) bus();
    uart_result_reporter #(.ERROR_COUNT(2), .RESULT_SIZE(4), .CLOCK_RATE(16), .BAUD_RATE(1))
        dut (.clk(clk), .reset(reset), .bus(bus));

    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;
    int frames = 0;
    bit in_frame = 1'b0;
    logic [7:0] m_exp, m_got;
    int m_bad, m_k;
    bit m_abort;
    logic m_want;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_line(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic req(input logic [15:0] d, input logic e);
        @(negedge clk);
        bus.data_in = d;
        bus.error_in = e;
        bus.ready_in = 1'b1;
        @(negedge clk);
        bus.ready_in = 1'b0;
    endtask

    task automatic drain(input string name);
        int t = 0;
        int f0;
        while ((exp_q.size() != 0 || in_frame) && t < 8000) begin
            @(posedge clk);
            t++;
        end
        check({name, "_drained"}, 32'(t < 8000), 1);
        f0 = frames;
        repeat (400) @(posedge clk);
        check({name, "_quiet"}, frames - f0, 0);
    endtask

    // Monitor: a frame is the 10*BP cycles from the start-bit edge; every cycle must match the ideal waveform.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!reset && bus.RsTx === 1'b0) begin
                frames++;
                in_frame = 1'b1;
                m_bad = 0;
                m_abort = 1'b0;
                m_got = '0;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                    m_exp = 8'hFF;
                end else m_exp = exp_q.pop_front();
                for (int i = 0; i < 10 * BP; i++) begin
                    if (i > 0) begin
                        @(posedge clk);
                        #1;
                    end
                    if (reset) begin
                        m_abort = 1'b1;
                        break;
                    end
                    m_k = i / BP;
                    m_want = m_k == 0 ? 1'b0 : m_k == 9 ? 1'b1 : m_exp[m_k-1];
                    if (bus.RsTx !== m_want) m_bad++;
                    if (i % BP == BP / 2 && m_k >= 1 && m_k <= 8) m_got[m_k-1] = bus.RsTx;
                end
                if (!m_abort) begin
                    check("frame_byte", m_got, m_exp);
                    check("frame_timing", m_bad, 0);
                end
                in_frame = 1'b0;
            end
        end
    end

    initial begin
        int lows;
        int t;
        int f0;
        bus.ready_in = 1'b0;
        bus.data_in = '0;
        bus.error_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_tx", bus.RsTx, 1);
        lows = 0;
        repeat (500) begin
            @(posedge clk);
            #1;
            if (bus.RsTx !== 1'b1) lows++;
        end
        check("idle_line", lows, 0);

        push_line("Result: 1A2F");
        req(16'h1A2F, 1'b0);
        drain("result_1a2f");

        push_line("Error: 1!");
        check("err_len", exp_q.size(), 11);
        req(16'hFFFF, 1'b1);
        drain("error_1");

        push_line("Result: 0000");
        @(negedge clk);
        bus.data_in = 16'h0000;
        bus.error_in = 1'b0;
        bus.ready_in = 1'b1;
        @(negedge clk);
        bus.ready_in = 1'b0;
        bus.data_in = 16'h1111;
        repeat (4) @(negedge clk);
        bus.data_in = 16'hBEEF;
        bus.ready_in = 1'b1;
        @(negedge clk);
        bus.ready_in = 1'b0;
        drain("ignore_in_send");

        push_line("Result: ABCD");
        push_line("Result: 0123");
        req(16'hABCD, 1'b0);
        repeat (20) @(negedge clk);
        req(16'h0123, 1'b0);
        drain("back_to_back");

        push_line("Result: 5555");
        f0 = frames;
        req(16'h5555, 1'b0);
        t = 0;
        while (frames < f0 + 5 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        check("fifth_frame_seen", 32'(t < 3000), 1);
        repeat (40) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_mid_tx", bus.RsTx, 1);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        f0 = frames;
        repeat (400) @(posedge clk);
        check("after_reset_quiet", frames - f0, 0);
        push_line("Result: 00FF");
        req(16'h00FF, 1'b0);
        drain("after_reset_line");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_result_reporter.md
# uart_result_reporter

Formats a hex result or an error code as an ASCII text line and transmits it over a UART TX line (8N1). It sits at the output of a computation core: one `ready_in` pulse queues one line. Hex nibbles are converted to ASCII, characters are buffered in a FIFO, and a serialiser drains the FIFO.

## Interface
- `ERROR_COUNT`, 2, number of error codes; error width `EW = $clog2(ERROR_COUNT)`; error hex digits `ED = ceil(EW/4)`.
- `RESULT_SIZE`, 4, number of hex digits in the result.
- `CLOCK_RATE`, 100_000_000, clock frequency in Hz.
- `BAUD_RATE`, 9600, line rate; bit period `BP = CLOCK_RATE/BAUD_RATE` cycles (integer division; 10416 at defaults).
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `ready_in`  in  1  request to send one line; sampled only while the formatter is IDLE.
- `data_in`  in  4*RESULT_SIZE  result value; most significant nibble is printed first.
- `error_in`  in  EW  error code; 0 means no error.
- `RsTx`  out  1  UART serial output; idle level is 1.

## Operation
- Nibble to ASCII conversion: 0–9 map to 0x30–0x39; A–F map to uppercase 0x41–0x46.
- Line selection, made at acceptance:
  - If `error_in == 0`: send "Result: " + RESULT_SIZE hex chars + CR LF. At defaults this is 14 chars.
  - Otherwise: send "Error: " + ED hex chars of `error_in` (zero-extended to 4*ED bits) + "!" + CR LF. At defaults this is 11 chars.
- `data_in` and `error_in` are captured in the acceptance cycle. Later changes do not affect a line already accepted.
- Formatter FSM:
  - IDLE: on `ready_in`, capture the inputs, go to SEND, and set the char counter to 0.
  - SEND: write one char per cycle into the FIFO, but only when the FIFO is not full; when full, stall and hold the counter. After the last char, return to IDLE.
  - `ready_in` is ignored in SEND. It is accepted again in the first IDLE cycle.
- FIFO: 8-bit data, depth = max(result line length, error line length) (14 at defaults).
  - Behaviour is first-in first-out.
  - A write when full is impossible because the formatter stalls. A read when empty is never issued.
  - Simultaneous read and write is allowed. The pointers wrap modulo the depth.
- Serialiser states: IDLE, START, DATA, STOP.
  - When IDLE and the FIFO is non-empty: pop one byte and transmit start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit lasts exactly BP cycles.
  - After the stop bit, return to IDLE and pop the next byte if one is present.
- Reset, whenever it occurs (including mid-frame or mid-line):
  - FSMs go to IDLE, FIFO is emptied, counters clear.
  - `RsTx` = 1 from the cycle after the reset edge.
  - Any partial frame or line is dropped.

## Timing
- Reset values: `RsTx` = 1, FIFO empty, both FSMs IDLE.
- `ready_in` high at edge N (in IDLE): chars are written at edges N+1 … N+L, with no stalls, since the FIFO cannot fill faster than the line length.
- The start bit of the first char appears on `RsTx` no later than 3 cycles after the first FIFO write.
- Within a line, consecutive frames are back-to-back: the gap between a stop bit's end and the next start bit is ≤ 2 cycles.
- A line of L chars occupies 10·L·BP cycles (±2 cycles per frame gap).
- A second `ready_in` accepted after the formatter returns to IDLE appends its line behind the current one. The formatter stalls on FIFO full; no data is lost.

## Test plan
Run with `CLOCK_RATE`=16, `BAUD_RATE`=1 (BP = 16) and a bit-accurate UART monitor sampling mid-bit.

1. Reset only: hold `reset` 2 cycles, then run 500 cycles → `RsTx` is constantly 1 and no start bit appears.
2. `data_in`=16'h1A2F, `error_in`=0, `ready_in` pulsed 1 cycle → bytes 52 65 73 75 6C 74 3A 20 31 41 32 46 0D 0A. Each bit lasts exactly 16 cycles; start bit 0, LSB first, stop bit 1.
3. `error_in`=1, `data_in`=16'hFFFF, 1-cycle pulse → bytes 45 72 72 6F 72 3A 20 31 21 0D 0A (11 bytes).
4. Pulse `ready_in` with 16'h0000, then pulse again 5 cycles later with 16'hBEEF while still in SEND. Change `data_in` to 16'h1111 on the cycle after the first acceptance. → Exactly one line, "Result: 0000" CR LF; nothing further.
5. Back-to-back: accept 16'hABCD, then accept 16'h0123 once the formatter is IDLE → "Result: ABCD" CR LF followed by "Result: 0123" CR LF. All 28 bytes are intact and in order.
6. Assert `reset` in the middle of the 5th frame of a result line → `RsTx` = 1 the next cycle and no further frames. A new request with 16'h00FF then produces the complete "Result: 00FF" CR LF.
